// File: rtl/a2d_arb_pkg.sv
// Shared definitions for the A2D arbiter: state encoding, requester indices and
// the default conversion timeout used by the motion block and its tests.
package a2d_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StDone
  } arb_state_e;

  localparam logic REQ_IR = 1'b0;
  localparam logic REQ_HK = 1'b1;

  localparam int unsigned TIMEOUT_CYC_DEFAULT = 4096;

endpackage

// File: rtl/a2d_arbiter.sv
// Round-robin sequencer for the shared A2D converter: one conversion in flight,
// latched channel/result, and a watchdog that aborts a conversion that never completes.
module a2d_arbiter
  import a2d_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_i,
  input  logic [2:0]  chnl0_i,
  input  logic        req1_i,
  input  logic [2:0]  chnl1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic [11:0] res_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        strt_cnv_o,
  output logic [2:0]  chnnl_o,
  input  logic        cnv_cmplt_i,
  input  logic [11:0] a2d_res_i
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYC);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic [2:0]        chnnl_q, chnnl_d;
  logic [11:0]       res_q, res_d;
  logic [TimerW-1:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= REQ_IR;
      last_q  <= REQ_HK;  // requester 0 wins the first tie
      err_q   <= 1'b0;
      chnnl_q <= 3'd0;
      res_q   <= 12'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      chnnl_q <= chnnl_d;
      res_q   <= res_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;
    chnnl_d = chnnl_q;
    res_d   = res_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle: begin
        if (req0_i && (!req1_i || (last_q == REQ_HK))) begin
          gnt_d   = REQ_IR;
          chnnl_d = chnl0_i;
          state_d = StStart;
        end else if (req1_i) begin
          gnt_d   = REQ_HK;
          chnnl_d = chnl1_i;
          state_d = StStart;
        end
      end
      StStart: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over a coincident timeout.
        if (cnv_cmplt_i) begin
          res_d   = a2d_res_i;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (timer_q == TimerMax) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        last_d  = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign strt_cnv_o = (state_q == StStart);
  assign busy_o     = (state_q != StIdle);
  assign done0_o    = (state_q == StDone) && (gnt_q == REQ_IR);
  assign done1_o    = (state_q == StDone) && (gnt_q == REQ_HK);
  assign err_o      = (state_q == StDone) && err_q;
  assign chnnl_o    = chnnl_q;
  assign res_o      = res_q;

endmodule
